// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader
//   Dumps a contiguous block of data-memory words onto a byte stream, least-significant byte
//   first. It shares the data memory's synchronous read port, which the system hands over to
//   this block while busy is high.
//
// Ports
//   clk, rst      system clock (rising edge), asynchronous active-high reset
//   start         one-cycle dump request, honoured in idle only
//   base_addr     first word address, latched when start is accepted
//   word_count    number of words to dump (0..2^ADDR_W), latched when start is accepted
//   mem_rd        read strobe to the data memory
//   mem_addr      word address for the read (zero when not reading)
//   mem_rdata     read data, valid the cycle after the edge that samples mem_rd
//   tx_data       stream byte
//   tx_valid      stream byte valid
//   tx_ready      downstream accepts the byte on an edge where tx_valid & tx_ready
//   busy          high from the accepting edge until the done pulse ends
//   done          one-cycle pulse when a dump completes
module dmem_dump_reader #(
  parameter int unsigned ADDR_W = 10,
  // Fixed at 32; the byte serialiser assumes four bytes per word.
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CntW-1:0]     remaining_q, remaining_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
          state_d     = (word_count == '0) ? StFinish : StRead;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        // Memory answers the cycle after the read strobe was sampled.
        rdata_d    = mem_rdata;
        byte_idx_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_ready) begin
          if (byte_idx_q == 2'd3) begin
            remaining_d = remaining_q - CntW'(1);
            addr_d      = addr_q + ADDR_W'(1);  // wraps naturally at 2^ADDR_W
            state_d     = (remaining_q == CntW'(1)) ? StFinish : StRead;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign mem_rd   = (state_q == StRead);
  assign mem_addr = mem_rd ? addr_q : '0;
  assign tx_valid = (state_q == StSend);
  assign tx_data  = tx_valid ? rdata_q[{byte_idx_q, 3'b000} +: 8] : 8'h00;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFinish);

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader: a behavioural data memory, a byte scoreboard fed when
// each dump is started, and a negedge monitor that pops and compares every accepted byte.
module tb_dmem_dump_reader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [31:0]   mem[1024];

  always #5 clk = ~clk;

  dmem_dump_reader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  // Synchronous-read memory; returns junk when not strobed so stray captures show up.
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : $urandom();

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: scoreboard pops, stall stability, read log, done count.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid_held", tx_valid, 1'b1);
        check("stall_data_held", tx_data, prev_data);
      end
      if (tx_valid) check("no_read_while_sending", mem_rd, 1'b0);
      if (tx_valid && tx_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL stream_extra_byte: observed=%0h expected=none", tx_data);
        end
        if (exp_q.size() > 0) check("stream_byte", tx_data, exp_q.pop_front());
      end
      if (mem_rd) addr_log.push_back(mem_addr);
      if (done) done_cnt++;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Drives start for one cycle; returns #1 after the accepting edge.
  task automatic start_dump(input int base, input int count, input bit expect_bytes);
    @(posedge clk);
    #1;
    start      = 1'b1;
    base_addr  = AW'(base);
    word_count = (AW + 1)'(count);
    if (expect_bytes) begin
      for (int w = 0; w < count; w++) begin
        for (int b = 0; b < 4; b++) exp_q.push_back(mem[(base + w) % 1024][8*b +: 8]);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || done) && n < bound);
    check("idle_timeout", (n < bound), 1'b1);
  endtask

  int d0;
  logic [7:0] pat[7];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();
    mem[4]    = 32'h1122_3344;
    mem[5]    = 32'hAABB_CCDD;
    mem[0]    = 32'h0102_0304;
    mem[1023] = 32'hDEAD_BEEF;
    mem[8]    = 32'h5566_7788;

    // Reset state
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 10'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Two-word dump with latency checks
    d0 = done_cnt;
    start_dump(4, 2, 1'b1);
    @(negedge clk);
    check("t1_busy_rise", busy, 1'b1);
    check("t1_read_strobe", mem_rd, 1'b1);
    check("t1_read_addr", mem_addr, 10'd4);
    check("t1_no_valid_read", tx_valid, 1'b0);
    @(negedge clk);
    check("t1_wait_no_rd", mem_rd, 1'b0);
    check("t1_no_valid_wait", tx_valid, 1'b0);
    @(negedge clk);
    check("t1_first_valid", tx_valid, 1'b1);
    check("t1_first_byte", tx_data, 8'h44);
    wait_idle(100);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_busy_low", busy, 1'b0);
    check("t1_all_bytes", exp_q.size(), 0);

    // Backpressure
    pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
    d0 = done_cnt;
    start_dump(0, 1, 1'b1);
    for (int n = 0; n < 10 && !tx_valid; n++) @(negedge clk);
    check("t2_valid_seen", tx_valid, 1'b1);
    tx_ready = pat[0][0];
    for (int i = 1; i < 7; i++) begin
      @(posedge clk);
      #1 tx_ready = pat[i][0];
    end
    wait_idle(50);
    tx_ready = 1'b1;
    check("t2_all_bytes", exp_q.size(), 0);
    check("t2_done_once", done_cnt - d0, 1);

    // Zero count
    addr_log.delete();
    d0 = done_cnt;
    start_dump(0, 0, 1'b0);
    @(negedge clk);
    check("t3_done_pulse", done, 1'b1);
    check("t3_no_valid", tx_valid, 1'b0);
    @(negedge clk);
    check("t3_done_fall", done, 1'b0);
    check("t3_busy_fall", busy, 1'b0);
    check("t3_no_reads", addr_log.size(), 0);
    check("t3_done_once", done_cnt - d0, 1);

    // Address wrap
    mem[0] = 32'hCAFE_F00D;
    addr_log.delete();
    start_dump(1023, 2, 1'b1);
    wait_idle(100);
    check("t4_read_count", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check("t4_addr0", addr_log[0], 10'd1023);
      check("t4_addr1", addr_log[1], 10'd0);
    end
    check("t4_all_bytes", exp_q.size(), 0);

    // Start while busy and start coincident with done are both ignored
    d0 = done_cnt;
    start_dump(4, 1, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = 10'd8; word_count = 11'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 20 && !done; n++) @(negedge clk);
    check("t5_done_seen", done, 1'b1);
    start = 1'b1; base_addr = 10'd8; word_count = 11'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t5_stays_idle", busy, 1'b0);
    end
    check("t5_done_once", done_cnt - d0, 1);
    check("t5_all_bytes", exp_q.size(), 0);

    // Reset mid-dump
    d0 = done_cnt;
    start_dump(4, 2, 1'b1);
    for (int n = 0; n < 10 && !tx_valid; n++) @(negedge clk);
    @(posedge clk);  // byte 0 accepted
    @(posedge clk);  // byte 1 accepted
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", tx_valid, 1'b0);
    check("t6_rst_data", tx_data, 8'h00);
    check("t6_rst_mem_rd", mem_rd, 1'b0);
    check("t6_rst_done", done, 1'b0);
    check("t6_bytes_before_rst", exp_q.size(), 6);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idle_after_rst", busy, 1'b0);
    check("t6_no_done", done_cnt - d0, 0);
    start_dump(4, 1, 1'b1);
    wait_idle(100);
    check("t6_restart_bytes", exp_q.size(), 0);
    check("t6_restart_done", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
